hamming_encoder_stream: RTL and testbench
=========================================

// Module: hamming_encoder_stream
// PURPOSE
//  Streaming Hamming encoder: the transmit-side counterpart of the hamming_decoder block.
//  Accepts 32-bit data words over valid/ready and emits 38-bit codewords over valid/ready.
//  Output is a 2-stage pipeline with full backpressure, optional single-bit error injection
//  for decoder test, and a count of emitted codewords.
// PARAMETERS
//  CNT_W   16  width of enc_count; wraps modulo 2**CNT_W
//  INJ_EN  1   1: error-injection path present; 0: inj_* inputs ignored, path tied off
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  in_valid   in   1   in_data/inj_* are valid
//  in_ready   out  1   block can accept a word this cycle
//  in_data    in   32  data word; bit 0 is d0
//  inj_flip   in   1   flip one codeword bit for this word (sampled with in_data)
//  inj_idx    in   6   codeword index to flip; 38..63 means no flip
//  out_valid  out  1   out_code is valid
//  out_ready  in   1   downstream accepts out_code
//  out_code   out  38  codeword, bit index i = Hamming position i+1
//  enc_count  out  CNT_W  number of completed output handshakes
// BEHAVIOUR
//  Codeword layout: parity bits at indices 2^k-1, k=0..5 (0,1,3,7,15,31); data bits
//   d0..d31 fill the remaining indices 2,4,5,6,8..14,16..30,32..37 in ascending order.
//  Parity k = even parity: XOR of all non-parity codeword bits at index i with bit k of (i+1) set.
//  Injection: when INJ_EN=1, inj_flip=1 and inj_idx<38, out_code[inj_idx] is inverted after
//   the parity computation. Otherwise out_code is the clean codeword.
//  Pipeline: S1 registers in_data/inj_*; S2 registers the computed codeword. Each stage has a valid bit.
//   S2 loads when s1_valid && (!s2_valid || out_ready).
//   in_ready = !s1_valid || S2-load condition; this is combinational from out_ready.
//   An input handshake is in_valid && in_ready.
//   out_valid = s2_valid.
//  Latency: a word accepted at edge N appears with out_valid=1 after edge N+1.
//   Throughput is 1 word/cycle when out_ready is held high.
//  Ordering: strictly in order; no word is dropped or duplicated.
//   out_code is held stable while out_valid && !out_ready.
//  Stall: with out_ready=0, exactly 2 words are held (S2, S1). in_ready then drops to 0.
//  enc_count increments on each out_valid && out_ready; it wraps from 2**CNT_W-1 to 0.
//  Simultaneous events: input accept and output handshake in the same cycle are both honoured.
//   Accept into an empty S1 while S2 drains is legal.
//  Reset (async, any time, including mid-stall): s1_valid=0, s2_valid=0, out_code=0,
//   enc_count=0. During reset in_ready=1 and out_valid=0. In-flight words are discarded.
// STRUCTURE
//  hamming_pkg: DATA_W=32, PAR_W=6, CW_W=38, and function is_parity_idx(i) ((i+1) is a power of 2).
//   The same layout constants are used by hamming_decoder.
//  Sub-module hamming_parity_gen: combinational 32->38 placement and parity.
//   The injection XOR and pipeline registers stay in the top level.
// TESTING
//  1 data 32'h0000_0000, out_ready=1 -> out_code 38'h00_0000_0000 two cycles later.
//  2 data 32'h0000_0001 -> 38'h00_0000_0007. data 32'hFFFF_FFFF -> 38'h3F_7FFF_FFF4.
//     Loop back through hamming_decoder for 10k random words -> decoded equals input.
//  3 out_ready=0, offer 3 words -> 2 accepted, in_ready=0. out_code held stable.
//     Raise out_ready -> all 3 emitted in order on consecutive cycles. enc_count=3.
//  4 data 0, inj_flip=1, inj_idx=5 -> 38'h00_0000_0020. inj_idx=38 -> 38'h0.
//     INJ_EN=0 with inj_flip=1, inj_idx=5 -> 38'h0.
//  5 assert rst while both stages are full and stalled -> out_valid=0, in_ready=1, enc_count=0
//     immediately (async). The first word after reset is encoded correctly.
//  6 CNT_W=4, 17 handshakes -> enc_count=1 (wrap).
//     Random valid/ready toggling -> scoreboard shows no loss or duplication.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(38,32) layout constants and helpers. The decoder side
// uses the same package, so the codeword layout lives in exactly one place.
package hamming_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int CW_W   = 38;
  localparam int IDX_W  = 6;

  // Codeword index i holds Hamming position i+1. A position is a parity
  // slot when it is a power of two.
  function automatic logic is_parity_idx(input int i);
    return ((i + 1) & i) == 0;
  endfunction

  // Indices of the data-carrying codeword bits that parity bit k covers:
  // non-parity indices whose position (i+1) has bit k set.
  function automatic logic [CW_W-1:0] parity_cover_mask(input int k);
    logic [CW_W-1:0] m;
    m = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (!is_parity_idx(i) && (((i + 1) >> k) & 1) == 1) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming(38,32) encoder: places the 32 data bits into the
// non-parity slots and fills the six even-parity bits.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   code
);

  logic [CW_W-1:0] placed;

  // Data bits in ascending order across indices 2,4-6,8-14,16-30,32-37;
  // parity slots (0,1,3,7,15,31) are left zero here.
  assign placed = {data[31:26], 1'b0, data[25:11], 1'b0, data[10:4],
                   1'b0, data[3:1], 1'b0, data[0], 2'b00};

  // Each parity bit is the XOR of the data slots it covers; parity slots
  // in placed are zero, so OR-ing them in is an insert.
  always_comb begin
    code = placed;
    for (int k = 0; k < PAR_W; k++) begin
      code[(1 << k) - 1] = ^(placed & parity_cover_mask(k));
    end
  end

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(38,32) encoder with a two-stage valid/ready pipeline,
// optional single-bit error injection and a count of emitted codewords.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready.
// in_ready depends combinationally on out_ready; out_valid is a register.
// Once out_valid is high, out_code holds until the transfer completes.
module hamming_encoder_stream
  import hamming_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_flip,
  input  logic [IDX_W-1:0]  inj_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_code,
  output logic [CNT_W-1:0]  enc_count
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_flip;
  logic [IDX_W-1:0]  s1_idx;

  logic              s2_valid;
  logic [CW_W-1:0]   s2_code;

  logic [CW_W-1:0]   clean_code;
  logic [CW_W-1:0]   inj_mask;
  logic              s2_load;
  logic              in_fire;
  logic              out_fire;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign out_code  = s2_code;

  hamming_parity_gen u_parity_gen (
    .data (s1_data),
    .code (clean_code)
  );

  // One-hot flip mask; indices 38..63 match no bit and leave the word clean.
  if (INJ_EN) begin : g_inj
    always_comb begin
      inj_mask = '0;
      for (int i = 0; i < CW_W; i++) begin
        if (s1_flip && (s1_idx == IDX_W'(i))) begin
          inj_mask[i] = 1'b1;
        end
      end
    end
  end else begin : g_no_inj
    assign inj_mask = '0;
  end

  // Stage 1: capture the incoming word; empties when it moves to stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_flip  <= 1'b0;
      s1_idx   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_flip  <= inj_flip;
      s1_idx   <= inj_idx;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register the finished codeword; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_code  <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_code  <= clean_code ^ inj_mask;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Count completed output transfers, wrapping naturally at 2**CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count <= '0;
    end else if (out_fire) begin
      enc_count <= enc_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
module tb_hamming_encoder_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: CNT_W=16, INJ_EN=1 ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        inj_flip = 1'b0;
  logic [5:0]  inj_idx = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [37:0] out_code;
  logic [15:0] enc_count;

  hamming_encoder_stream #(.CNT_W(16), .INJ_EN(1'b1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inj_flip  (inj_flip),
    .inj_idx   (inj_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .enc_count (enc_count)
  );

  // ---------------- DUT B: CNT_W=4, INJ_EN=0 ----------------
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [31:0] b_in_data = '0;
  logic        b_inj_flip = 1'b0;
  logic [5:0]  b_inj_idx = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [37:0] b_out_code;
  logic [3:0]  b_enc_count;

  hamming_encoder_stream #(.CNT_W(4), .INJ_EN(1'b0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .inj_flip  (b_inj_flip),
    .inj_idx   (b_inj_idx),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_code  (b_out_code),
    .enc_count (b_enc_count)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decoder-side view of a codeword: syndrome is the XOR of positions of set bits.
  function automatic int syndrome(input logic [37:0] c);
    int s;
    s = 0;
    for (int i = 0; i < 38; i++) if (c[i]) s = s ^ (i + 1);
    return s;
  endfunction

  function automatic logic [31:0] extract(input logic [37:0] c);
    logic [31:0] d;
    int j;
    d = '0;
    j = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = c[pos-1];
        j++;
      end
    end
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  // One word through an idle pipeline with out_ready=1; checks latency and code.
  task automatic send_single(input string tag, input logic [31:0] d,
                             input logic f, input logic [5:0] idx,
                             input logic [37:0] exp);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; inj_flip = f; inj_idx = idx;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; inj_flip = 1'b0;
    check({tag, "_not_yet"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_code"}, out_code, exp);
    @(posedge clk); #1;
    exp_count++;
    check({tag, "_drained"}, out_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        hold_prev;
    logic [37:0] code_prev;
    logic        hs_in, hs_out;
    int          guard;

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_enc_count", enc_count, 0);
    check("rst_out_code", out_code, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;

    // Directed encodes, including injection cases
    send_single("zero",   32'h0000_0000, 1'b0, 6'd0,  38'h00_0000_0000);
    send_single("one",    32'h0000_0001, 1'b0, 6'd0,  38'h00_0000_0007);
    send_single("two",    32'h0000_0002, 1'b0, 6'd0,  38'h00_0000_0019);
    send_single("ones",   32'hFFFF_FFFF, 1'b0, 6'd0,  38'h3F_7FFF_FFF4);
    send_single("inj5",   32'h0000_0000, 1'b1, 6'd5,  38'h00_0000_0020);
    send_single("inj38",  32'h0000_0000, 1'b1, 6'd38, 38'h00_0000_0000);
    send_single("inj0",   32'h0000_0000, 1'b1, 6'd0,  38'h00_0000_0001);
    check("count_after_directed", enc_count, 16'(exp_count));

    // Reset while both stages are full and stalled
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("stall_full_in_ready", in_ready, 0);
    check("stall_full_out_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_enc_count", enc_count, 0);
    check("async_rst_out_code", out_code, 0);
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    exp_count = 0;

    // Stall with three offered words, then release
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0001;
    #1 check("st_a_ready", in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    in_data = 32'h0000_0002;
    #1 check("st_b_ready", in_ready, 1);
    @(posedge clk); #1;
    check("st_a_valid", out_valid, 1);
    check("st_a_code", out_code, 38'h00_0000_0007);
    @(negedge clk);
    in_data = 32'hFFFF_FFFF;
    #1 check("st_c_blocked", in_ready, 0);
    @(posedge clk); #1;
    check("st_hold1_code", out_code, 38'h00_0000_0007);
    check("st_hold1_ready", in_ready, 0);
    check("st_hold1_count", enc_count, 0);
    @(posedge clk); #1;
    check("st_hold2_code", out_code, 38'h00_0000_0007);
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("st_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check("st_b_valid", out_valid, 1);
    check("st_b_code", out_code, 38'h00_0000_0019);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    check("st_c_valid", out_valid, 1);
    check("st_c_code", out_code, 38'h3F_7FFF_FFF4);
    @(posedge clk); #1;
    check("st_empty", out_valid, 0);
    check("st_count", enc_count, 3);
    exp_count = 3;

    // Random valid/ready toggling with scoreboard
    hold_prev = 1'b0;
    code_prev = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (hold_prev) begin
        check("rand_hold_valid", out_valid, 1);
        check("rand_hold_code", out_code, code_prev);
      end
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        check("rand_q_nonempty", (exp_q.size() > 0), 1);
        check("rand_syndrome", syndrome(out_code), 0);
        if (exp_q.size() > 0) check("rand_data", extract(out_code), exp_q.pop_front());
        exp_count++;
      end
      if (hs_in) exp_q.push_back(in_data);
      hold_prev = out_valid && !out_ready;
      code_prev = out_code;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      #1;
      if (out_valid) begin
        check("drain_syndrome", syndrome(out_code), 0);
        check("drain_data", extract(out_code), exp_q.pop_front());
        exp_count++;
      end
      @(negedge clk);
      guard++;
    end
    check("rand_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check("rand_count", enc_count, 16'(exp_count));
    check("rand_idle", out_valid, 0);

    // DUT B: injection disabled, 4-bit counter wrap after 17 transfers
    b_out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_data = 32'h0; b_inj_flip = 1'b1; b_inj_idx = 6'd5;
      @(posedge clk); #1;
      if (i == 1) begin
        check("noinj_valid", b_out_valid, 1);
        check("noinj_code", b_out_code, 38'h00_0000_0000);
      end
      if (i == 16) check("wrap_pre", b_enc_count, 4'd15);
    end
    @(negedge clk) b_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_count", b_enc_count, 4'd1);
    check("wrap_idle", b_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
